// File: rtl/reg_write_arbiter_pkg.sv
// Shared definitions for the register write arbiter: state encoding and defaults.
package reg_write_arbiter_pkg;

    localparam int unsigned DEF_N_REQ = 4;
    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_ACK   = 2'b10
    } state_t;

endpackage

// File: rtl/reg_write_arbiter_reg8_en.sv
// Shared storage register with enable; holds its value while EN is low.
module reg8_en
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             res,
    input  logic             EN,
    input  logic [WIDTH-1:0] Reg_In,
    output logic [WIDTH-1:0] Reg_Out
);

    // Load on enable, clear on synchronous reset.
    always_ff @(posedge clk) begin
        if (res) begin
            Reg_Out <= '0;
        end else if (EN) begin
            Reg_Out <= Reg_In;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter sharing one enable register among N_REQ requesters.
// Each transaction is IDLE -> GRANT (register write) -> ACK (ack pulse, pointer advance).
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic                       clk,
    input  logic                       res,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ*WIDTH-1:0]     wdata,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           ack,
    output logic [$clog2(N_REQ)-1:0]   owner,
    output logic                       busy,
    output logic [WIDTH-1:0]           Reg_Out
);

    localparam int unsigned OW = $clog2(N_REQ);

    state_t           state, state_nxt;
    logic [OW-1:0]    ptr, ptr_nxt, owner_nxt;
    logic [N_REQ-1:0] gnt_nxt, ack_nxt;
    logic             reg_en;
    logic [WIDTH-1:0] reg_in;

    // First set request at or after start, ascending and wrapping.
    function automatic logic [OW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [OW-1:0]    start);
        logic [OW-1:0] pick;
        logic          found;
        int unsigned   idx;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(start) + k) % N_REQ;
            if (!found && r[idx]) begin
                pick  = OW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Successor index with wrap from N_REQ-1 back to 0.
    function automatic logic [OW-1:0] inc_wrap(input logic [OW-1:0] v);
        return (32'(v) == N_REQ - 1) ? '0 : OW'(32'(v) + 1);
    endfunction

    // Next-state and next-output logic; grant and ack are registered from these.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        gnt_nxt   = '0;
        ack_nxt   = '0;
        unique case (state)
            ST_IDLE: begin
                if (|req) begin
                    owner_nxt          = rr_pick(req, ptr);
                    gnt_nxt[owner_nxt] = 1'b1;
                    state_nxt          = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt_nxt   = gnt;
                ack_nxt   = gnt;
                state_nxt = ST_ACK;
            end
            ST_ACK: begin
                ptr_nxt   = inc_wrap(owner);
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, pointer and output registers.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= ST_IDLE;
            ptr   <= '0;
            owner <= '0;
            gnt   <= '0;
            ack   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            owner <= owner_nxt;
            gnt   <= gnt_nxt;
            ack   <= ack_nxt;
        end
    end

    assign busy   = (state != ST_IDLE);
    assign reg_en = (state == ST_GRANT);
    assign reg_in = wdata[owner*WIDTH +: WIDTH];

    reg8_en #(
        .WIDTH (WIDTH)
    ) u_reg (
        .clk     (clk),
        .res     (res),
        .EN      (reg_en),
        .Reg_In  (reg_in),
        .Reg_Out (Reg_Out)
    );

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: a transaction-level model predicts each
// serviced write; a negedge monitor compares DUT outputs and pops on every ack.
module tb_reg_write_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           res = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] wdata = '0;
    logic [N-1:0]   gnt, ack;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   Reg_Out;

    reg_write_arbiter #(
        .N_REQ (N),
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .res     (res),
        .req     (req),
        .wdata   (wdata),
        .gnt     (gnt),
        .ack     (ack),
        .owner   (owner),
        .busy    (busy),
        .Reg_Out (Reg_Out)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        int           idx;
        logic [W-1:0] data;
    } txn_t;

    txn_t q[$];
    int   ack_log[$];

    // Reference model state: a service slot lasts 3 edges, pointer advances after it.
    int           m_cnt   = 0;
    int           m_ptr   = 0;
    int           m_owner = 0;
    logic [W-1:0] m_reg   = '0;
    logic [W-1:0] m_data  = '0;
    logic [N-1:0] exp_gnt = '0;
    logic [N-1:0] exp_ack = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: picks a winner from the pointer when free, then runs a 3-edge slot.
    always @(posedge clk) begin
        if (res) begin
            m_cnt   = 0;
            m_ptr   = 0;
            m_owner = 0;
            m_reg   = '0;
            exp_gnt = '0;
            exp_ack = '0;
            q.delete();
        end else if (m_cnt == 0) begin
            exp_gnt = '0;
            exp_ack = '0;
            if (req != '0) begin
                for (int k = N - 1; k >= 0; k--)
                    if (req[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
                m_data  = wdata[m_owner*W +: W];
                q.push_back('{m_owner, m_data});
                exp_gnt = N'(1) << m_owner;
                m_cnt   = 2;
            end
        end else if (m_cnt == 2) begin
            m_reg   = m_data;
            exp_ack = exp_gnt;
            m_cnt   = 1;
        end else begin
            exp_gnt = '0;
            exp_ack = '0;
            m_ptr   = (m_owner + 1) % N;
            m_cnt   = 0;
        end
    end

    // Monitor: compare outputs each cycle and retire one scoreboard entry per ack.
    always @(negedge clk) begin
        txn_t t;
        int   a;
        chk("gnt", 32'(gnt), 32'(exp_gnt));
        chk("ack", 32'(ack), 32'(exp_ack));
        chk("busy", 32'(busy), 32'(exp_gnt != '0));
        chk("reg_out", 32'(Reg_Out), 32'(m_reg));
        chk("owner", 32'(owner), 32'(m_owner));
        if (ack != '0) begin
            a = 0;
            for (int i = 0; i < N; i++) if (ack[i]) a = i;
            ack_log.push_back(a);
            if (q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL ack_unexpected: got ack %0h expected no ack at %0t", ack, $time);
            end else begin
                t = q.pop_front();
                chk("ack_idx", 32'(ack), 32'(N'(1) << t.idx));
                chk("ack_data", 32'(Reg_Out), 32'(t.data));
            end
        end
    end

    // Requester behaviour: drop req on ack (or randomly during grant), raise new requests.
    // mode 0: no new requests, 1: all requesters continuously, 2: random.
    task automatic drive_cycles(input int n, input int mode);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #2;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    req[i] = 1'b0;
                end else if (gnt[i]) begin
                    if (mode == 2 && $urandom_range(0, 3) == 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)) begin
                        req[i] = 1'b1;
                        wdata[i*W +: W] = (mode == 1) ? W'(17 * (i + 1)) : W'($urandom);
                    end
                end
            end
        end
    endtask

    task automatic pulse_reset();
        res = 1'b1;
        req = '0;
        @(posedge clk);
        #2;
        res = 1'b0;
    endtask

    initial begin
        int exp_order[5];
        int seen;
        exp_order = '{0, 1, 2, 3, 0};

        // Reset held for two cycles, then idle.
        res = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        res = 1'b0;
        drive_cycles(5, 0);
        chk("rst_reg", 32'(Reg_Out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);

        // Single write from requester 2, then a quiet period holding the value.
        ack_log.delete();
        req[2] = 1'b1;
        wdata[2*W +: W] = 8'h77;
        drive_cycles(10, 0);
        chk("single_hold", 32'(Reg_Out), 32'h77);

        // Pointer now at 3: requesters 3 and 0 together are served 3 then 0.
        req[0] = 1'b1;
        wdata[0 +: W] = W'($urandom);
        req[3] = 1'b1;
        wdata[3*W +: W] = W'($urandom);
        drive_cycles(12, 0);
        chk("wrap_count", 32'(ack_log.size()), 32'd3);
        if (ack_log.size() == 3) begin
            chk("wrap_first", 32'(ack_log[0]), 32'd2);
            chk("wrap_second", 32'(ack_log[1]), 32'd3);
            chk("wrap_third", 32'(ack_log[2]), 32'd0);
        end

        // Fairness: all four requesting continuously from pointer 0.
        pulse_reset();
        ack_log.delete();
        drive_cycles(30, 1);
        drive_cycles(20, 0);
        chk("fair_count", 32'(ack_log.size() >= 5), 32'd1);
        seen = (ack_log.size() < 5) ? ack_log.size() : 5;
        for (int i = 0; i < seen; i++) chk("fair_order", 32'(ack_log[i]), 32'(exp_order[i]));

        // Random traffic including withdrawals during grant.
        drive_cycles(400, 2);
        drive_cycles(20, 0);
        chk("drain_queue", 32'(q.size()), 32'd0);

        // Reset during GRANT aborts the write of 0xAA.
        req[1] = 1'b1;
        wdata[1*W +: W] = 8'hAA;
        for (int c = 0; c < 10 && !gnt[1]; c++) begin
            @(posedge clk);
            #2;
        end
        chk("abort_granted", 32'(gnt[1]), 32'h1);
        pulse_reset();
        chk("abort_reg", 32'(Reg_Out), 32'h0);
        chk("abort_gnt", 32'(gnt), 32'h0);
        chk("abort_ack", 32'(ack), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_owner", 32'(owner), 32'h0);
        drive_cycles(6, 0);
        chk("abort_reg_after", 32'(Reg_Out), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
